seq_divmod_select: RTL

- Multi-cycle, parametrised successor to the team's combinational divide/modulo/compare/select datapath.
- Computes z = (a % b == zero) ? (a / b) : (c / d) using one shared iterative restoring divider instead of three parallel combinational dividers.
- Skips the c/d division when the a/b remainder matches.
- Valid/ready handshakes on input and output, with a registered result, so it drops into pipelined datapaths.

---
 rtl/seq_divmod_select_pkg.sv | 15 +
 rtl/seq_divmod_select_if.sv | 33 +++
 rtl/seq_divmod_select_div_iter.sv | 79 +++++++
 rtl/seq_divmod_select.sv | 112 +++++++++++
 4 files changed

// File: rtl/seq_divmod_select_pkg.sv
// Shared types and defaults for the sequential divide/modulo/select block.
package seq_divmod_pkg;

  localparam int unsigned DEF_WIDTH = 64;

  typedef enum logic [2:0] {
    IDLE,
    DIV_AB,
    CHECK,
    DIV_CD,
    LOAD,
    DONE
  } state_e;

endpackage

// File: rtl/seq_divmod_select_if.sv
// Operand/result handshake bundle for seq_divmod_select.
interface seq_divmod_select_if
  import seq_divmod_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] zero;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             sel_ab;
  logic             div_by_zero;

  // Producer/consumer side of the block.
  modport master (
    output in_valid, a, b, c, d, zero, out_ready,
    input  in_ready, out_valid, z, sel_ab, div_by_zero
  );

  // The block itself.
  modport slave (
    input  in_valid, a, b, c, d, zero, out_ready,
    output in_ready, out_valid, z, sel_ab, div_by_zero
  );

endinterface

// File: rtl/seq_divmod_select_div_iter.sv
// Iterative restoring unsigned divider, one quotient bit per cycle, MSB first.
// The start cycle performs the first step directly on the dividend/divisor inputs,
// so a division occupies exactly WIDTH step edges; done pulses in the cycle after.
module div_iter
  import seq_divmod_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q, quo_q, dvd_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] src_rem, src_quo, src_dvd, src_dvs;
  logic [WIDTH-1:0] rem_sh, rem_nx, quo_nx;
  logic             ge;

  // One restoring step, sourced from the inputs on start and from state otherwise.
  // rem never reaches bit WIDTH-1 before the final shift, so dropping it is lossless.
  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? '0 : quo_q;
    src_dvd = start ? dividend : dvd_q;
    src_dvs = start ? divisor : dvs_q;
    rem_sh  = {src_rem[WIDTH-2:0], src_dvd[WIDTH-1]};
    ge      = (rem_sh >= src_dvs);
    rem_nx  = ge ? (rem_sh - src_dvs) : rem_sh;
    quo_nx  = {src_quo[WIDTH-2:0], ge};
  end

  // Shift registers, step counter and completion pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      rem_q  <= rem_nx;
      quo_q  <= quo_nx;
      dvd_q  <= dividend << 1;
      dvs_q  <= divisor;
      cnt_q  <= CNT_W'(1);
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (busy_q) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
      dvd_q <= dvd_q << 1;
      cnt_q <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/seq_divmod_select.sv
// z = (a % b == zero) ? a / b : c / d, computed on one shared iterative divider.
module seq_divmod_select
  import seq_divmod_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input logic               Clk,
  input logic               Rst,
  seq_divmod_select_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] b_q, c_q, d_q, zero_q;
  logic [WIDTH-1:0] z_q;
  logic             sel_q, dbz_q, cd_kick_q;

  logic             div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_dvd, div_dvs, div_quo, div_rem;
  logic             rem_match;
  logic             in_ready, out_valid;

  div_iter #(
    .WIDTH(WIDTH)
  ) u_div (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (div_start),
    .dividend (div_dvd),
    .divisor  (div_dvs),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  assign rem_match = (div_rem == zero_q);

  // Next-state, divider start/operand select and handshake outputs.
  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    div_dvd   = bus.a;
    div_dvs   = bus.b;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Never load over a division still in flight.
        in_ready = !div_busy;
        if (bus.in_valid && !div_busy) begin
          div_start = 1'b1;
          state_d   = DIV_AB;
        end
      end
      DIV_AB: if (div_done) state_d = CHECK;
      CHECK:  state_d = rem_match ? DONE : DIV_CD;
      DIV_CD: begin
        div_dvd   = c_q;
        div_dvs   = d_q;
        div_start = cd_kick_q;
        if (div_done) state_d = LOAD;
      end
      LOAD: state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand latches and registered result.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= IDLE;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      zero_q    <= '0;
      z_q       <= '0;
      sel_q     <= 1'b0;
      dbz_q     <= 1'b0;
      cd_kick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Registered kick keeps the full-width compare off the divider load path.
      cd_kick_q <= (state_q == CHECK) && !rem_match;
      if (state_q == IDLE && div_start) begin
        b_q    <= bus.b;
        c_q    <= bus.c;
        d_q    <= bus.d;
        zero_q <= bus.zero;
      end
      if (state_q == CHECK && rem_match) begin
        z_q   <= div_quo;
        sel_q <= 1'b1;
        dbz_q <= (b_q == '0);
      end else if (state_q == LOAD) begin
        z_q   <= div_quo;
        sel_q <= 1'b0;
        dbz_q <= (d_q == '0);
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.z           = z_q;
  assign bus.sel_ab      = sel_q;
  assign bus.div_by_zero = dbz_q;

endmodule
